// File: rtl/cache_plru_tree_pkg.sv
// Shared types and sizing helpers for the tree pseudo-LRU replacement tracker.
// Consumers: cache_plru_tree (top, optional PLRU_STATS_EN counters) and plru_tree_select.
package cache_plru_tree_pkg;

  localparam int unsigned PLRU_MAX_WAYS = 16;

  // Widest flag vector any instance can need (heap nodes 1..PLRU_MAX_WAYS-1).
  typedef logic [PLRU_MAX_WAYS-2:0] plru_flags_t;

  typedef enum logic {
    PLRU_INIT,
    PLRU_RUN
  } plru_state_t;

  function automatic int unsigned plru_flag_bits(input int unsigned num_ways);
    return (num_ways > 1) ? num_ways - 1 : 1;
  endfunction

endpackage

// File: rtl/plru_tree_select.sv
// Combinational tree-PLRU helper: victim choice (invalid first, lock-aware walk,
// lock-blind walk when everything is locked) and MRU path update of the flags.
module plru_tree_select
  import cache_plru_tree_pkg::*;
#(
  parameter int unsigned NUM_WAYS        = 4,
  parameter int unsigned WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int unsigned FLAG_WIDTH      = plru_flag_bits(NUM_WAYS)
) (
  input  logic [FLAG_WIDTH-1:0]      flags,
  input  logic [NUM_WAYS-1:0]        valid_mask,
  input  logic [NUM_WAYS-1:0]        lock_mask,
  input  logic [WAY_INDEX_WIDTH-1:0] new_mru,
  output logic [WAY_INDEX_WIDTH-1:0] victim_c,
  output logic [FLAG_WIDTH-1:0]      flags_upd_c,
  output logic                       took_invalid_c,
  output logic                       all_locked_c
);

  localparam int unsigned LEVELS = $clog2(NUM_WAYS);

  logic [NUM_WAYS-1:0] free_ways;

  assign free_ways      = ~valid_mask & ~lock_mask;
  assign took_invalid_c = |free_ways;

  generate
    if (NUM_WAYS == 1) begin : g_single
      logic unused_mru;
      assign unused_mru   = ^new_mru;
      assign victim_c     = '0;
      assign flags_upd_c  = flags;
      assign all_locked_c = lock_mask[0];
    end else begin : g_tree
      localparam int unsigned NODE_W = LEVELS + 1;

      logic [NUM_WAYS-1:0]   node_flag;
      logic [2*NUM_WAYS-1:0] sub_locked;
      logic [LEVELS-1:0]     first_free;
      logic [LEVELS-1:0]     walk_way;
      logic [NODE_W-1:0]     leaf;

      // Heap-indexed view of the flags; slot 0 is unused.
      assign node_flag = {flags, 1'b0};

      // A node is fully locked when both of its children are.
      always_comb begin
        sub_locked = '0;
        sub_locked[2*NUM_WAYS-1:NUM_WAYS] = lock_mask;
        for (int i = NUM_WAYS - 1; i >= 1; i--) begin
          sub_locked[i] = sub_locked[2*i] & sub_locked[2*i+1];
        end
      end

      always_comb begin
        first_free = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
          if (free_ways[w]) first_free = LEVELS'(w);
        end
      end

      // Follow the flags, steering around locked subtrees unless every way is locked.
      always_comb begin
        logic [NODE_W-1:0] node;
        node = NODE_W'(1);
        for (int l = 0; l < int'(LEVELS); l++) begin
          node = {node[LEVELS-1:0], node_flag[node[LEVELS-1:0]]};
          if (!sub_locked[1] && sub_locked[node]) node[0] = ~node[0];
        end
        walk_way = node[LEVELS-1:0];
      end

      assign victim_c     = took_invalid_c ? first_free : walk_way;
      assign all_locked_c = sub_locked[1];
      assign leaf         = {1'b1, new_mru};

      for (genvar i = 1; i < NUM_WAYS; i++) begin : g_node
        localparam int unsigned SHIFT = LEVELS - ($clog2(i + 1) - 1);
        assign flags_upd_c[i-1] = ((leaf >> SHIFT) == NODE_W'(i)) ? ~leaf[SHIFT-1] : flags[i-1];
      end
    end
  endgenerate

endmodule

// File: rtl/cache_plru_tree.sv
// Per-set tree pseudo-LRU tracker with post-reset clearing sweep.
// Define PLRU_STATS_EN to add saturating victim-selection statistics outputs.
module cache_plru_tree
  import cache_plru_tree_pkg::*;
#(
  parameter int unsigned NUM_SETS        = 64,
  parameter int unsigned NUM_WAYS        = 4,
  parameter int unsigned SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int unsigned WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_en,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set,
  input  logic [NUM_WAYS-1:0]        fill_valid_mask,
  input  logic [NUM_WAYS-1:0]        fill_lock_mask,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way,
  input  logic                       access_en,
  input  logic [SET_INDEX_WIDTH-1:0] access_set,
  input  logic                       access_update_en,
  input  logic [WAY_INDEX_WIDTH-1:0] access_update_way,
  output logic                       init_done
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]                stat_fills,
  output logic [31:0]                stat_fill_invalid,
  output logic [31:0]                stat_all_locked
`endif
);

  localparam int unsigned FLAG_WIDTH = plru_flag_bits(NUM_WAYS);
  localparam logic [SET_INDEX_WIDTH-1:0] LAST_SET = SET_INDEX_WIDTH'(NUM_SETS - 1);

  plru_state_t                state, state_next;
  logic [SET_INDEX_WIDTH-1:0] sweep_cnt;
  logic                       run;
  logic                       read_en, write_en;
  logic [SET_INDEX_WIDTH-1:0] read_set, write_set, set_q;
  logic                       was_fill_q, acc_q;
  logic [NUM_WAYS-1:0]        valid_q, lock_q;
  logic [FLAG_WIDTH-1:0]      mem [NUM_SETS];
  logic [FLAG_WIDTH-1:0]      rd_flags, upd_flags, write_flags;
  logic [WAY_INDEX_WIDTH-1:0] victim, new_mru;
  logic                       took_invalid, all_locked;

  assign run = (state == PLRU_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PLRU_INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == PLRU_RUN);
      if (state == PLRU_INIT) sweep_cnt <= sweep_cnt + SET_INDEX_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == PLRU_INIT && sweep_cnt == LAST_SET) state_next = PLRU_RUN;
  end

  // Sweep writes zeros during INIT; in RUN, reads come from requests and writes from updates.
  always_comb begin
    read_en   = 1'b0;
    read_set  = fill_set;
    write_en  = 1'b1;
    write_set = sweep_cnt;
    fill_way  = '0;
    if (state == PLRU_RUN) begin
      read_en   = fill_en | access_en;
      read_set  = fill_en ? fill_set : access_set;
      write_en  = was_fill_q | access_update_en;
      write_set = set_q;
      fill_way  = victim;
    end
  end

  assign new_mru     = was_fill_q ? victim : access_update_way;
  assign write_flags = run ? upd_flags : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      was_fill_q <= 1'b0;
      acc_q      <= 1'b0;
      set_q      <= '0;
      valid_q    <= '0;
      lock_q     <= '0;
    end else begin
      was_fill_q <= run & fill_en;
      acc_q      <= run & access_en & ~fill_en;
      if (read_en) begin
        set_q   <= read_set;
        valid_q <= fill_valid_mask;
        lock_q  <= fill_lock_mask;
      end
    end
  end

  // Flag storage: one read, one write port, a same-set write forwards to the read.
  always_ff @(posedge clk) begin
    if (write_en) mem[write_set] <= write_flags;
    if (read_en) rd_flags <= (write_en && write_set == read_set) ? write_flags : mem[read_set];
  end

  plru_tree_select #(
    .NUM_WAYS       (NUM_WAYS),
    .WAY_INDEX_WIDTH(WAY_INDEX_WIDTH),
    .FLAG_WIDTH     (FLAG_WIDTH)
  ) u_select (
    .flags         (rd_flags),
    .valid_mask    (valid_q),
    .lock_mask     (lock_q),
    .new_mru       (new_mru),
    .victim_c      (victim),
    .flags_upd_c   (upd_flags),
    .took_invalid_c(took_invalid),
    .all_locked_c  (all_locked)
  );

`ifdef PLRU_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fills        <= '0;
      stat_fill_invalid <= '0;
      stat_all_locked   <= '0;
    end else if (was_fill_q) begin
      if (stat_fills != '1) stat_fills <= stat_fills + 32'd1;
      if (took_invalid && stat_fill_invalid != '1) stat_fill_invalid <= stat_fill_invalid + 32'd1;
      if (all_locked && stat_all_locked != '1) stat_all_locked <= stat_all_locked + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = took_invalid ^ all_locked;
`endif

  a_update_after_access: assert property (@(posedge clk) disable iff (reset)
    access_update_en |-> acc_q);
  a_no_req_during_init: assert property (@(posedge clk) disable iff (reset)
    !init_done |-> !(fill_en || access_en));

endmodule

// File: doc/cache_plru_tree.md
Name: cache_plru_tree

Overview:
Parametrised tree pseudo-LRU replacement tracker for the L1/L2 caches. It supports any power-of-two way count up to 16, with tree logic generated from NUM_WAYS rather than hard-coded per way count. Fill-victim selection prefers invalid ways and skips locked ways. After reset it clears its own state with a hardware sweep. It sits beside the tag arrays: fill requests return a victim way one cycle later, and hit updates promote a way to MRU.

Parameters:
NUM_SETS, 64, number of cache sets (power of two, >=1)
NUM_WAYS, 4, ways per set; power of two, 1..16
SET_INDEX_WIDTH, $clog2(NUM_SETS), set index width (min 1)
WAY_INDEX_WIDTH, $clog2(NUM_WAYS), way index width (min 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
fill_en  in  1  request victim for fill_set; fill wins over access
fill_set  in  SET_INDEX_WIDTH  set being filled
fill_valid_mask  in  NUM_WAYS  per-way valid bits of fill_set, sampled with fill_en
fill_lock_mask  in  NUM_WAYS  ways excluded from replacement, sampled with fill_en
fill_way  out  WAY_INDEX_WIDTH  victim way, valid the cycle after fill_en
access_en  in  1  read LRU state for access_set (cycle 1 of lookup)
access_set  in  SET_INDEX_WIDTH  set looked up
access_update_en  in  1  hit: promote access_update_way (cycle after access_en)
access_update_way  in  WAY_INDEX_WIDTH  way that hit
init_done  out  1  0 during post-reset sweep, 1 afterwards

Behaviour:
- State: NUM_WAYS-1 flag bits per set (1 bit when NUM_WAYS=1, unused), heap-indexed. Node 1 is the root; the children of node i are 2i and 2i+1; way w is leaf NUM_WAYS+w. Flag 0 means the LRU side is left.
- Storage: sram_1r1w, READ_DURING_WRITE NEW_DATA, so a back-to-back access to the same set sees the updated flags.
- Read cycle N: read_en = fill_en | access_en; read_set = fill_en ? fill_set : access_set. Register set, was_fill, valid_mask and lock_mask.
- Cycle N+1, victim selection (combinational from registered data), in priority order:
  - (a) lowest-index way that is invalid and unlocked;
  - (b) otherwise a tree walk from the root following the flags; at any node whose flagged subtree is entirely locked, take the other child;
  - (c) if every way is locked, a plain tree walk that ignores locks.
- Cycle N+1, update: write_en = was_fill | access_update_en, new_mru = was_fill ? fill_way : access_update_way. Every node on new_mru's root-to-leaf path is set to point away from it; all other flags are kept.
- Simultaneous fill_en and access_en: fill wins; the access read is dropped, and the client must not assert access_update_en the next cycle.
- NUM_WAYS=1: fill_way=0, no SRAM writes needed.
- Reset (any time, asynchronous): FSM -> INIT, sweep counter=0, init_done=0, was_fill=0, fill_way=0 when INIT.
- INIT: writes all-zero flags to set[counter], one set per cycle; counter increments. After the write of set NUM_SETS-1 → RUN, init_done=1 the following cycle. INIT lasts exactly NUM_SETS cycles after reset deasserts.
- Requests during INIT are ignored (no reads, no updates). Reset mid-sweep restarts from set 0.
- Simulation assertions: access_update_en only the cycle after an accepted access_en; no fill_en/access_en while init_done=0.

Optional Feature:
PLRU_STATS_EN:
- Defined: adds outputs stat_fills[31:0], stat_fill_invalid[31:0], stat_all_locked[31:0], all reset to 0 and saturating at all-ones.
  - stat_fills counts victim selections.
  - stat_fill_invalid counts selections resolved by rule (a).
  - stat_all_locked counts selections resolved by rule (c).
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- defines package gets: plru_flags_t width function plru_flag_bits(NUM_WAYS) = max(1, NUM_WAYS-1); a PLRU_MAX_WAYS=16 constant; and the plru_state_t enum {PLRU_INIT, PLRU_RUN}.
- One sub-module, plru_tree_select: purely combinational, generate-loop tree walk and path update. Inputs are flags, valid/lock masks and new_mru; outputs are victim way and updated flags. It is reusable by other caches.

Test Plan:
- Reset with NUM_SETS=64 → init_done=0 for exactly 64 cycles then 1; a fill to set 5 with all valid, no locks → fill_way=0.
- NUM_WAYS=4, set 3, all valid: four back-to-back fills → ways 0,2,1,3; then hit way 1, then fill → way 2.
- NUM_WAYS=8, fill_valid_mask=8'b1111_0111, lock=0 → fill_way=3; with lock_mask=8'b0000_1000 → tree walk result, never 3.
- NUM_WAYS=16, lock_mask=16'h00FF, all valid, flags zero → fill_way=8; lock_mask=16'hFFFF → fill_way=0 (rule c).
- fill_en and access_en together on sets 2 and 7 → only set 2 updated; set 7 flags unchanged on a later read. Reset asserted mid-INIT at counter=20 → sweep restarts at set 0.
- With PLRU_STATS_EN: 10 fills, 3 to sets with an invalid way → stat_fills=10, stat_fill_invalid=3.
